regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, entry width; ADDR_W, default 5, address width (depth 2**ADDR_W); NUM_RD, default 2, read ports (1..4); NUM_WR, default 1, write ports (1..2); PC_W, default 32, PC width; PC_DELAY, default 4, PC-to-writeback stages (1..8).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset, synchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, same packing.
- we  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- busy  out  1  clear sequence in progress.
- pc_in  in  PC_W  PC of instruction entering the pipeline.
- trace_valid  out  NUM_WR  committed write per port, one-cycle pulse.
- trace_pc  out  PC_W  PC associated with the traced writes.
- trace_addr  out  NUM_WR*ADDR_W  traced write addresses.
- trace_data  out  NUM_WR*DATA_W  traced write data.

Function
REQ-003 Entry 0 SHALL always read 0; writes to address 0 SHALL be discarded and SHALL NOT raise trace_valid.
REQ-004 Reads SHALL be combinational from array contents; writes SHALL commit on the rising edge when we[j]=1, busy=0 and address non-zero.
REQ-005 With two write ports targeting the same non-zero address in one cycle, port 1 SHALL win; only trace_valid[1] SHALL pulse.
REQ-006 Clear FSM states: CLEAR and READY. While reset=1, state SHALL be CLEAR with index 1.
REQ-007 In CLEAR, one entry per cycle SHALL be zeroed (index 1 .. 2**ADDR_W-1), taking 2**ADDR_W-1 cycles after reset deasserts; the cycle the last index is zeroed, the FSM SHALL move to READY.
REQ-008 busy SHALL be 1 in CLEAR and 0 in READY; while busy, all writes SHALL be ignored, all rd_data SHALL be 0, and trace_valid SHALL be 0.
REQ-009 A reset asserted mid-clear SHALL restart at index 1.
REQ-010 pc_in SHALL pass through a PC_DELAY-stage register chain; trace_pc SHALL equal pc_in sampled PC_DELAY cycles before the write edge.
REQ-011 trace outputs SHALL be registered, valid the cycle after the commit edge, and held at their last values when trace_valid=0.
REQ-012 The PC chain SHALL keep shifting while busy.

Reset
REQ-013 Reset SHALL set busy=1, trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0, and all PC chain stages to 0; array contents SHALL be cleared only by the FSM.

Configuration
REQ-014 With REGFILE_BYPASS_EN defined: a read whose address matches a same-cycle committing write SHALL return wr_data (port 1 priority), and rd_data SHALL still be 0 while busy. Without it: such a read SHALL return the old contents.

Structure
REQ-015 A shared package SHALL hold the FSM state enum, the parameter defaults, and the pack/unpack index helper functions.
REQ-016 The PC delay chain SHALL be a sub-module named pc_delay_line (params PC_W, PC_DELAY).

Verification
REQ-017 Benches SHALL cover:
- Reset 1 cycle, ADDR_W=5: busy=1 for 31 cycles after deassert, then 0; all reads return 0.
- Reset re-asserted at clear index 10: clear restarts, busy=1 for 31 more cycles.
- Write x5=0xDEADBEEF, next cycle read port 0 addr 5 -> 0xDEADBEEF; write addr 0 -> reads 0, no trace pulse.
- NUM_WR=2, both write addr 7 (0x11 / 0x22) -> x7=0x22, trace_valid=2'b10.
- Same-cycle write x3=0x55 with read addr 3 -> 0x55 with REGFILE_BYPASS_EN, old value without it.
- PC_DELAY=4, pc_in=0x100 at cycle t, write at edge t+4 -> trace_pc=0x100 at t+5.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: clear FSM states,
// parameter defaults and helpers that locate a port's field in a packed bus.
package regfile_mp_pkg;

    localparam int unsigned DEFAULT_DATA_W   = 32;
    localparam int unsigned DEFAULT_ADDR_W   = 5;
    localparam int unsigned DEFAULT_NUM_RD   = 2;
    localparam int unsigned DEFAULT_NUM_WR   = 1;
    localparam int unsigned DEFAULT_PC_W     = 32;
    localparam int unsigned DEFAULT_PC_DELAY = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clearState_t;

    // Lowest bit of port `port` inside a bus packing fields of `width` bits.
    function automatic int unsigned fieldLo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

    // Highest bit of port `port` inside the same packing.
    function automatic int unsigned fieldHi(input int unsigned port, input int unsigned width);
        return port * width + width - 1;
    endfunction

endpackage

// File: rtl/pc_delay_line.sv
// Shift register that delays the instruction PC to line up with writeback.
// Keeps shifting regardless of register-file state; reset zeroes every stage.
module pc_delay_line
    import regfile_mp_pkg::*;
#(
    parameter int unsigned PC_W     = DEFAULT_PC_W,
    parameter int unsigned PC_DELAY = DEFAULT_PC_DELAY
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_in,
    output logic [PC_W-1:0] pc_out
);

    logic [PC_W-1:0] stages [PC_DELAY];

    // Shift the PC one stage per cycle; synchronous clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PC_DELAY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= pc_in;
            for (int i = 1; i < PC_DELAY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign pc_out = stages[PC_DELAY-1];

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with a hard-wired zero entry, a post-reset clear
// sequence that sweeps entries 1..depth-1 one per cycle, and a commit trace
// port tagged with the delayed instruction PC.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle committing
// write data to matching reads (highest-numbered write port wins).
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD   = DEFAULT_NUM_RD,
    parameter int unsigned NUM_WR   = DEFAULT_NUM_WR,
    parameter int unsigned PC_W     = DEFAULT_PC_W,
    parameter int unsigned PC_DELAY = DEFAULT_PC_DELAY
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     busy,
    input  logic [PC_W-1:0]          pc_in,
    output logic [NUM_WR-1:0]        trace_valid,
    output logic [PC_W-1:0]          trace_pc,
    output logic [NUM_WR*ADDR_W-1:0] trace_addr,
    output logic [NUM_WR*DATA_W-1:0] trace_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Entry 0 is never written and never read out.
    logic [DATA_W-1:0] mem [DEPTH];

    clearState_t       state;
    logic [ADDR_W-1:0] clearIdx;

    logic [ADDR_W-1:0] wAddr [NUM_WR];
    logic [DATA_W-1:0] wData [NUM_WR];
    logic [NUM_WR-1:0] commit;
    logic [PC_W-1:0]   pcDelayed;

    assign busy = (state == CLEAR);

    for (genvar j = 0; j < NUM_WR; j++) begin : gWrUnpack
        assign wAddr[j] = wr_addr[fieldLo(j, ADDR_W) +: ADDR_W];
        assign wData[j] = wr_data[fieldLo(j, DATA_W) +: DATA_W];
    end

    // Clear sequencer: sweep entries 1..DEPTH-1, then settle in READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clearIdx <= ADDR_W'(1);
        end else if (state == CLEAR) begin
            if (clearIdx == ADDR_W'(DEPTH - 1)) begin
                state <= READY;
            end else begin
                clearIdx <= clearIdx + 1'b1;
            end
        end
    end

    // Decide which write ports actually land; a higher port hitting the same
    // entry suppresses the lower one so only the winner is traced.
    always_comb begin
        commit = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            commit[j] = we[j] && !reset && !busy && (wAddr[j] != '0);
        end
        for (int j = 0; j < NUM_WR; j++) begin
            for (int i = j + 1; i < NUM_WR; i++) begin
                if (commit[i] && (wAddr[i] == wAddr[j])) begin
                    commit[j] = 1'b0;
                end
            end
        end
    end

    // Array update: clear sweep has sole ownership while busy.
    always_ff @(posedge clk) begin
        if (!reset && (state == CLEAR)) begin
            mem[clearIdx] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (commit[j]) begin
                    mem[wAddr[j]] <= wData[j];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRead
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;

        assign ra = rd_addr[fieldLo(k, ADDR_W) +: ADDR_W];

        // Combinational read with zero entry and busy masking.
        always_comb begin
            val = mem[ra];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (commit[j] && (wAddr[j] == ra)) begin
                    val = wData[j];
                end
            end
`endif
            if (busy || (ra == '0)) begin
                val = '0;
            end
        end

        assign rd_data[fieldHi(k, DATA_W):fieldLo(k, DATA_W)] = val;
    end

    pc_delay_line #(
        .PC_W     (PC_W),
        .PC_DELAY (PC_DELAY)
    ) uPcDelay (
        .clk    (clk),
        .reset  (reset),
        .pc_in  (pc_in),
        .pc_out (pcDelayed)
    );

    // Registered trace; address/data of idle ports keep their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid <= '0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else begin
            trace_valid <= commit;
            if (|commit) begin
                trace_pc <= pcDelayed;
            end
            for (int j = 0; j < NUM_WR; j++) begin
                if (commit[j]) begin
                    trace_addr[fieldLo(j, ADDR_W) +: ADDR_W] <= wAddr[j];
                    trace_data[fieldLo(j, DATA_W) +: DATA_W] <= wData[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: clear sequencing, table of write/read
// vectors, write-port conflicts, same-cycle read behaviour and PC tracing.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int PW = 32;
    localparam int PD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             busy;
    logic [PW-1:0]    pc_in;
    logic [NW-1:0]    trace_valid;
    logic [PW-1:0]    trace_pc;
    logic [NW*AW-1:0] trace_addr;
    logic [NW*DW-1:0] trace_data;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .NUM_WR   (NW),
        .PC_W     (PW),
        .PC_DELAY (PD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .pc_in       (pc_in),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data)
    );

    typedef struct packed {
        logic [1:0]  tv;
        logic [31:0] pc;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
    } trace_t;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  tv;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic        monOn = 1'b0;
    logic [31:0] pcHist [1024];
    trace_t      sbq [$];
    trace_t      monRec;
    vec_t        vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        pcHist[cyc % 1024] = pc_in;
        @(posedge clk);
        #1;
        cyc++;
        pc_in = 32'h1000 + 32'(cyc) * 4;
    endtask

    task automatic setWrite(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                            input logic [4:0] a1, input logic [31:0] d1);
        we      = w;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    task automatic pushTrace(input logic [1:0] tv, input logic [4:0] a0, input logic [31:0] d0,
                             input logic [4:0] a1, input logic [31:0] d1);
        trace_t r;
        r.tv = tv;
        r.pc = pcHist[(cyc - PD) % 1024];
        r.a0 = a0;
        r.d0 = d0;
        r.a1 = a1;
        r.d1 = d1;
        sbq.push_back(r);
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Trace scoreboard: every pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (monOn && trace_valid !== '0) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL trace_unexpected: got valid %b, expected no pulse", trace_valid);
            end else begin
                monRec = sbq.pop_front();
                check("trace_valid", 64'(trace_valid), 64'(monRec.tv));
                check("trace_pc", 64'(trace_pc), 64'(monRec.pc));
                if (monRec.tv[0]) begin
                    check("trace_addr0", 64'(trace_addr[4:0]), 64'(monRec.a0));
                    check("trace_data0", 64'(trace_data[31:0]), 64'(monRec.d0));
                end
                if (monRec.tv[1]) begin
                    check("trace_addr1", 64'(trace_addr[9:5]), 64'(monRec.a1));
                    check("trace_data1", 64'(trace_data[63:32]), 64'(monRec.d1));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int t;
        logic [31:0] expByp;

        //        we     wa0  wd0            wa1   wd1            tv     ra0   ra1   e0             e1
        vecs[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0,        2'b00, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{2'b11, 5'd7, 32'h11,       5'd7, 32'h22,       2'b10, 5'd7, 5'd5, 32'h22,       32'hDEADBEEF};
        vecs[3] = '{2'b11, 5'd9, 32'hAAAA0009, 5'd31, 32'hBBBB001F, 2'b11, 5'd9, 5'd31, 32'hAAAA0009, 32'hBBBB001F};
        vecs[4] = '{2'b10, 5'd0, 32'h0,        5'd5, 32'hCAFEF00D, 2'b10, 5'd5, 5'd9, 32'hCAFEF00D, 32'hAAAA0009};
        vecs[5] = '{2'b00, 5'd9, 32'hFFFFFFFF, 5'd0, 32'h0,        2'b00, 5'd9, 5'd7, 32'hAAAA0009, 32'h22};
        vecs[6] = '{2'b11, 5'd3, 32'h33,       5'd0, 32'h99,       2'b01, 5'd3, 5'd0, 32'h33,       32'h0};

        reset   = 1'b1;
        rd_addr = '0;
        pc_in   = 32'h1000;
        setWrite(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        tick();

        check("rst_busy", 64'(busy), 64'd1);
        check("rst_trace_valid", 64'(trace_valid), 64'd0);
        check("rst_trace_pc", 64'(trace_pc), 64'd0);
        check("rst_trace_addr", 64'(trace_addr), 64'd0);
        check("rst_trace_data", 64'(trace_data), 64'd0);
        rd_addr = {5'd7, 5'd5};
        #1;
        check("rst_rd_data", 64'(rd_data), 64'd0);

        // Initial clear sequence.
        monOn = 1'b1;
        reset = 1'b0;
        countBusy(n);
        check("clear_cycles", 64'(n), 64'd31);
        check("busy_after_clear", 64'(busy), 64'd0);
        for (int a = 0; a < 16; a++) begin
            rd_addr = {5'(a + 16), 5'(a)};
            #1;
            check("cleared_rd0", 64'(rd_data[31:0]), 64'd0);
            check("cleared_rd1", 64'(rd_data[63:32]), 64'd0);
            tick();
        end

        // Table of write-then-read vectors.
        for (int i = 0; i < 7; i++) begin
            setWrite(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1);
            if (vecs[i].tv != 2'b00) begin
                pushTrace(vecs[i].tv, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1);
            end
            tick();
            setWrite(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            check($sformatf("vec%0d_rd0", i), 64'(rd_data[31:0]), 64'(vecs[i].e0));
            check($sformatf("vec%0d_rd1", i), 64'(rd_data[63:32]), 64'(vecs[i].e1));
            tick();
        end

        // Trace fields of idle ports hold the last committed values.
        check("trace_addr_hold", 64'(trace_addr), 64'({5'd5, 5'd3}));
        check("trace_data_hold", 64'(trace_data), {32'hCAFEF00D, 32'h00000033});

        // Same-cycle read of an entry being written.
        setWrite(2'b01, 5'd3, 32'h55, 5'd0, 32'h0);
        pushTrace(2'b01, 5'd3, 32'h55, 5'd0, 32'h0);
        rd_addr = {5'd0, 5'd3};
`ifdef REGFILE_BYPASS_EN
        expByp = 32'h55;
`else
        expByp = 32'h33;
`endif
        #1;
        check("same_cycle_rd", 64'(rd_data[31:0]), 64'(expByp));
        tick();
        setWrite(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check("after_write_rd", 64'(rd_data[31:0]), 64'h55);

        setWrite(2'b11, 5'd3, 32'h66, 5'd3, 32'h77);
        pushTrace(2'b10, 5'd3, 32'h66, 5'd3, 32'h77);
        rd_addr = {5'd3, 5'd3};
`ifdef REGFILE_BYPASS_EN
        expByp = 32'h77;
`else
        expByp = 32'h55;
`endif
        #1;
        check("same_cycle_conflict_rd", 64'(rd_data[63:32]), 64'(expByp));
        tick();
        setWrite(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check("conflict_winner_rd", 64'(rd_data[31:0]), 64'h77);
        tick();

        // PC alignment: pc_in seen at cycle t traced for a write at edge t+4.
        pc_in = 32'h100;
        t = cyc;
        tick();
        tick();
        tick();
        tick();
        check("pc_test_cycle", 64'(cyc - t), 64'd4);
        setWrite(2'b01, 5'd10, 32'hA5A5A5A5, 5'd0, 32'h0);
        pushTrace(2'b01, 5'd10, 32'hA5A5A5A5, 5'd0, 32'h0);
        tick();
        setWrite(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        check("pc_trace_valid", 64'(trace_valid), 64'b01);
        check("pc_trace_pc", 64'(trace_pc), 64'h100);
        tick();

        // Reset mid-clear, with writes attempted while busy.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        setWrite(2'b01, 5'd20, 32'h0BAD0BAD, 5'd0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        check("midclear_busy", 64'(busy), 64'd1);
        rd_addr = {5'd31, 5'd31};
        #1;
        check("busy_rd_masked", 64'(rd_data), 64'd0);
        setWrite(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        countBusy(n);
        check("restart_clear_cycles", 64'(n), 64'd31);
        rd_addr = {5'd31, 5'd20};
        #1;
        check("restart_rd20", 64'(rd_data[31:0]), 64'd0);
        check("restart_rd31", 64'(rd_data[63:32]), 64'd0);

        tick();
        tick();
        tick();
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
